kf_bank_reader: RTL
===================

// Module: kf_bank_reader
// PURPOSE
//  Read-out engine for the Data_Bank read port B: streams a run of consecutive bank words to a
//  host/output interface over a valid/ready handshake, with a 2-entry output FIFO for full-rate
//  transfer under backpressure. Sits between mem_reg (dirb/B) and the result-unload path.
// PARAMETERS
//  W      24  data width (matches bank word)
//  NR     32  number of bank registers; addresses wrap at NR-1 -> 0 (NR need not be a power of 2)
//  ADDRW  5   bank address width
// PORTS
//  clk      in   1        clock, all state on posedge
//  rst      in   1        synchronous reset, active-high
//  start    in   1        launch a transfer; sampled only when busy=0
//  base     in   ADDRW    first bank address of the run (sampled with start)
//  len      in   ADDRW+1  number of words (sampled with start; 0..NR, >NR clamped to NR)
//  abort    in   1        synchronous cancel of the current run
//  busy     out  1        high from the cycle after start is accepted until done/abort
//  done     out  1        one-cycle pulse after the last word is accepted downstream
//  rd_addr  out  ADDRW    to bank dirb
//  rd_en    out  1        high in cycles where rd_data is captured (debug/arbitration)
//  rd_data  in   W        from bank B (combinational read, same cycle as rd_addr)
//  m_valid  out  1        output word valid
//  m_ready  in   1        downstream ready
//  m_data   out  W        output word (FIFO head)
//  m_last   out  1        qualifies final word of the run (valid only with m_valid)
//  m_addr   out  ADDRW    bank address of m_data (only with KF_BANK_RD_TAG_EN)
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, rd_en=0, rd_addr=0, m_valid=0, m_last=0, m_data=0, FIFO empty.
//  - FSM IDLE -> READ -> DRAIN -> IDLE.
//    IDLE: start=1 latches addr=base, rem=min(len,NR). rem=0 -> done pulse next cycle, stay IDLE,
//      busy stays 0, no beats. Else -> READ. start while busy=1 is ignored (no queueing).
//    READ: rd_addr=addr. Issue when FIFO count<2 OR a pop occurs this cycle (m_valid&m_ready).
//      Issue: rd_en=1, push {rd_data, last=(rem==1), addr}; addr<=(addr==NR-1)?0:addr+1; rem--.
//      After pushing the rem==1 word -> DRAIN.
//    DRAIN: no reads; when the last word pops -> done=1 for one cycle, busy=0, IDLE.
//  - Handshake: transfer when m_valid&m_ready. m_valid/m_data/m_last hold stable until accepted.
//    m_valid never depends combinationally on m_ready.
//  - Latency: start at edge N -> rd_en in cycle N+1 -> m_valid in cycle N+2.
//    Throughput 1 word/cycle with m_ready=1. Done asserted the cycle after the last pop.
//  - FIFO: 2 entries, simultaneous push+pop at count=2 is legal; count never exceeds 2 or underflows.
//  - Wrap: base=NR-2, len=4 reads NR-2, NR-1, 0, 1.
//  - abort (any state): next cycle IDLE, FIFO flushed, m_valid=0, busy=0, no done pulse.
//    abort wins over start in the same cycle.
//  - rst mid-run: identical to abort, plus all outputs forced to reset values.
//  - Bank write-through: if the bank is written at rd_addr in an issue cycle, the written value is
//    what the reader captures; the reader adds no ordering of its own.
// CONFIGURATION
//  KF_BANK_RD_TAG_EN defined: FIFO carries the address; m_addr port exists (reset 0)
//    and equals the source address of m_data.
//  Undefined: no m_addr port, FIFO width W+1, all other behaviour identical.
// TESTING
//  1. Bank[i]=i*3; start base=4 len=3, m_ready=1 -> m_data 12,15,18 in cycles N+2..N+4;
//     m_last on 18; done at N+5.
//  2. base=30 len=4 (NR=32) -> rd_addr 30,31,0,1; with TAG_EN, m_addr matches each beat.
//  3. len=8; m_ready toggles 1,0,0,1,... -> all 8 words in order, none dropped or duplicated;
//     rd_en stalls while FIFO full.
//  4. len=0 -> done pulse next cycle; m_valid never asserts; busy stays 0. len=40 -> exactly 32 beats.
//  5. abort after 3rd beat of a len=10 run -> m_valid=0 next cycle, no done;
//     new start base=0 len=1 -> 1 beat, done.
//  6. rst asserted mid-run with m_valid=1 -> next cycle all outputs at reset values;
//     start during busy ignored (beat count unchanged).

Source files
------------

// File: rtl/kf_bank_reader.sv
// kf_bank_reader: read-out engine for bank read port B.
// Streams a run of consecutive bank words (wrapping at NR-1 -> 0) onto a
// valid/ready output stream through a 2-entry FIFO.
// Optional feature macro: KF_BANK_RD_TAG_EN. When it is defined, each FIFO
// entry also carries its source address, and m_addr is present.
//
// Handshake: a word transfers on a rising clk edge where m_valid && m_ready.
// m_valid, m_data and m_last stay stable while m_valid=1 and m_ready=0.
// m_valid comes from FIFO occupancy only and never depends on m_ready in
// the same cycle.
module kf_bank_reader #(
    parameter int W     = 24,
    parameter int NR    = 32,
    parameter int ADDRW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDRW-1:0] base,
    input  logic [ADDRW:0]   len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [ADDRW-1:0] rd_addr,
    output logic             rd_en,
    input  logic [W-1:0]     rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data,
    output logic             m_last,
`ifdef KF_BANK_RD_TAG_EN
    output logic [ADDRW-1:0] m_addr,
`endif
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One FIFO entry: bank word, end-of-run flag and, optionally, the source address.
    typedef struct packed {
        logic [W-1:0]     data;
        logic             last;
`ifdef KF_BANK_RD_TAG_EN
        logic [ADDRW-1:0] addr;
`endif
    } entry_t;

    localparam logic [ADDRW:0]   NR_LEN    = (ADDRW+1)'(NR);
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(NR - 1);

    state_t           state;
    logic [ADDRW-1:0] addr;
    logic [ADDRW:0]   rem;
    logic             done_r;

    entry_t           head;
    entry_t           tail;
    logic [1:0]       count;

    logic             pop;
    logic             issue;
    logic [ADDRW:0]   len_clamped;
    entry_t           new_entry;

    assign pop         = (count != 2'd0) && m_ready;
    // A read is issued when the FIFO has room now, or gains a slot from a pop in this cycle.
    assign issue       = (state == ST_READ) && ((count != 2'd2) || pop);
    assign len_clamped = (len > NR_LEN) ? NR_LEN : len;

    // Build the entry pushed in an issue cycle from the bank's combinational read data.
    always_comb begin
        new_entry      = '0;
        new_entry.data = rd_data;
        new_entry.last = (rem == (ADDRW+1)'(1));
`ifdef KF_BANK_RD_TAG_EN
        new_entry.addr = addr;
`endif
    end

    // Control FSM: latch the run, step the address and word count, and pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            addr   <= '0;
            rem    <= '0;
            done_r <= 1'b0;
        end else if (abort) begin
            state  <= ST_IDLE;
            rem    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr <= base;
                        rem  <= len_clamped;
                        if (len_clamped == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        addr <= (addr == LAST_ADDR) ? '0 : addr + ADDRW'(1);
                        rem  <= rem - (ADDRW+1)'(1);
                        if (rem == (ADDRW+1)'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && head.last) begin
                        done_r <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-entry FIFO: head drives the output stream, tail holds the second word.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({issue, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= new_entry;
                    end else begin
                        tail <= new_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= new_entry;
                    end else begin
                        head <= tail;
                        tail <= new_entry;
                    end
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

    // Output mapping from registered state.
    always_comb begin
        busy      = (state != ST_IDLE);
        done      = done_r;
        rd_addr   = addr;
        rd_en     = issue;
        m_valid   = (count != 2'd0);
        m_data    = head.data;
        m_last    = head.last && (count != 2'd0);
        dbg_state = state;
`ifdef KF_BANK_RD_TAG_EN
        m_addr    = head.addr;
`endif
    end

endmodule
